piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out stage directly upstream of shift_register. It accepts an N-bit word over a valid/ready handshake and drives shift_register's data_in and ena one bit at a time, MSB first. After N strobes, the downstream q holds the word. Each bit can be stretched over several clocks so slower serial links can be emulated in benches.

Parameters:
N, 4, word width in bits; must be ≥ 2.
BIT_PERIOD, 1, clocks each bit is held on serial_out; must be ≥ 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
word_in  input  N  parallel word; sampled only at acceptance.
valid_in  input  1  upstream has a word.
ready_out  output  1  block can accept a word this cycle.
serial_out  output  1  current bit; connects to shift_register data_in.
ena_out  output  1  capture strobe; connects to shift_register ena.
busy  output  1  a word is being serialised.
done  output  1  one-cycle pulse after the last strobe.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values, held while rst is high: state=IDLE, ready_out=1, serial_out=0, ena_out=0, busy=0, done=0, internal word and counters=0.
- FSM has three states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - ready_out=1, busy=0.
  - When valid_in & ready_out at a clock edge: latch word_in, bit_idx=N-1, tick=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - ready_out=0, busy=1.
  - serial_out = latched[bit_idx].
  - tick counts 0..BIT_PERIOD-1.
  - ena_out=1 only when tick==BIT_PERIOD-1, i.e. the last cycle of each bit period. With BIT_PERIOD=1, ena_out is high for N consecutive cycles.
  - On a strobe cycle with bit_idx>0: decrement bit_idx, tick=0.
  - On a strobe cycle with bit_idx==0: go to DONE.
- Latency: the first SHIFT cycle is the cycle after acceptance. The last strobe is N·BIT_PERIOD cycles after the acceptance edge.
- DONE:
  - Lasts exactly one cycle: done=1, ena_out=0, serial_out=0, ready_out=0, busy=0.
  - Then returns to IDLE.
  - Minimum spacing between accepted words is N·BIT_PERIOD+2 cycles.
- valid_in and word_in are ignored outside IDLE. word_in changing mid-shift has no effect.
- serial_out holds 0 whenever ena_out is not asserted in IDLE or DONE.
- Counter widths:
  - bit_idx is $clog2(N) bits. It must not underflow; the terminal index is 0.
  - tick is $clog2(BIT_PERIOD+1) bits. No wrap is needed beyond BIT_PERIOD-1.
- Reset asserted mid-SHIFT aborts immediately and asynchronously to reset values. The partial word is discarded and no done pulse is produced.

Optional Feature:
Macro: PISO_PARITY_EN.
- Defined: after bit 0, one extra bit period carries even parity (XOR of the latched word). It gets its own ena_out strobe, so there are N+1 strobes in total. DONE follows the parity strobe, and the minimum spacing becomes (N+1)·BIT_PERIOD+2 cycles.
- Undefined: exactly N strobes. No parity logic is present.

Decomposition:
- Package piso_pkg:
  - state enum type piso_state_t {IDLE, SHIFT, DONE}.
  - Width helper localparams are computed in the module from N and BIT_PERIOD; the package holds no localparams.
- Sub-module bit_timer (parameter BIT_PERIOD; ports clk, rst, run, strobe):
  - Owns the tick counter.
  - strobe is high on the last tick while run=1.
  - The counter clears when run=0.

Test Plan:
1. N=4, BIT_PERIOD=1, word 4'b1010, valid for one cycle:
   - ena_out high for 4 cycles with serial_out 1,0,1,0.
   - done pulses the next cycle.
   - A chained shift_register ends with q=4'b1010.
2. BIT_PERIOD=3, word 4'b0110:
   - Each bit is held 3 cycles; ena_out is high only on the 3rd cycle of each.
   - Last strobe is 12 cycles after acceptance.
   - done arrives at cycle 13.
3. valid_in held high with word_in changing each cycle:
   - Only the word present at the acceptance edge is serialised.
   - ready_out is low from acceptance through DONE.
   - The next word is accepted on the first IDLE cycle.
4. rst pulsed high mid-way, after 2 strobes of 4'b1111:
   - Outputs go to reset values immediately and no done pulse occurs.
   - After release, 4'b0001 serialises cleanly to q=0001.
5. PISO_PARITY_EN defined, word 4'b1011:
   - 5 strobes with serial_out 1,0,1,1,1 (parity=1).
   - Word 4'b1001 gives a final parity bit of 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } piso_state_t;

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and flags the last one.
module bit_timer #(
    parameter int BIT_PERIOD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic strobe,
    output logic strobe_next
);

    localparam int TW = $clog2(BIT_PERIOD + 1);
    localparam logic [TW-1:0] LAST = TW'(BIT_PERIOD - 1);

    logic [TW-1:0] tick_q, tick_d;

    assign strobe = run && (tick_q == LAST);

    always_comb begin
        tick_d = '0;
        if (run && !strobe) begin
            tick_d = tick_q + 1'b1;
        end
    end

    // Lets the owner register its strobe output one cycle ahead of the tick.
    assign strobe_next = (tick_d == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a shift register, MSB first.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
//
// state | meaning
// IDLE  | ready for a word
// SHIFT | driving bits onto serial_out, strobing ena_out
// DONE  | one-cycle completion pulse
module piso_serializer
    import piso_pkg::*;
#(
    parameter int N          = 4,
    parameter int BIT_PERIOD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] word_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         serial_out,
    output logic         ena_out,
    output logic         busy,
    output logic         done
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    piso_state_t   state_q, state_d;
    logic [N-1:0]  word_q, word_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ready_q, serial_q, ena_q, busy_q, done_q;
    logic          ready_d, serial_d, ena_d, busy_d, done_d;
    logic          run, strobe, strobe_next;
    logic          next_bit;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    assign run = (state_q == SHIFT);

    bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .strobe      (strobe),
        .strobe_next (strobe_next)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in && ready_q) begin
                    word_d  = word_in;
                    idx_d   = IDX_TOP;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (strobe) begin
`ifdef PISO_PARITY_EN
                    if (par_q) begin
                        state_d = DONE;
                    end else if (idx_q == '0) begin
                        par_d = 1'b1;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
`else
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they can be registered
    // without lagging the state by a cycle.
    always_comb begin
`ifdef PISO_PARITY_EN
        next_bit = par_d ? (^word_d) : word_d[idx_d];
`else
        next_bit = word_d[idx_d];
`endif
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d == SHIFT);
        done_d   = (state_d == DONE);
        ena_d    = busy_d && strobe_next;
        serial_d = busy_d ? next_bit : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b1;
            serial_q <= 1'b0;
            ena_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            serial_q <= serial_d;
            ena_q    <= ena_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign ready_out  = ready_q;
    assign serial_out = serial_q;
    assign ena_out    = ena_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (BIT_PERIOD 1 and 3) checked every
// cycle against a transaction-level model, plus directed vectors and corners.
module tb_piso_serializer;

    localparam int N = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] word_in [2];
    logic [1:0]   valid_in;
    logic [1:0]   ready_out, serial_out, ena_out, busy, done;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        piso_serializer #(
            .N          (N),
            .BIT_PERIOD ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .word_in    (word_in[g]),
            .valid_in   (valid_in[g]),
            .ready_out  (ready_out[g]),
            .serial_out (serial_out[g]),
            .ena_out    (ena_out[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bp_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [NB-1:0] stream_of(input logic [N-1:0] w);
`ifdef PISO_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Model: k = cycles since acceptance (0 = idle). Bits are NB slots of bp
    // cycles each, followed by one done cycle.
    int            k [2];
    logic [NB-1:0] exp_bits [2];
    logic [NB-1:0] q_model [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] = 0;
            end else if (k[i] == 0) begin
                if (valid_in[i]) begin
                    k[i] = 1;
                    exp_bits[i] = stream_of(word_in[i]);
                end
            end else if (k[i] == NB * bp_of(i) + 1) begin
                k[i] = 0;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                int bp;
                int nt;
                int b;
                logic [4:0] e;
                logic [4:0] a;
                bp = bp_of(i);
                nt = NB * bp;
                if (k[i] == 0) begin
                    e = 5'b10000;
                end else if (k[i] <= nt) begin
                    b = (k[i] - 1) / bp;
                    e = {1'b0, 1'b1, ((k[i] % bp) == 0), exp_bits[i][NB-1-b], 1'b0};
                end else begin
                    e = 5'b00001;
                end
                a = {ready_out[i], busy[i], ena_out[i], serial_out[i], done[i]};
                check($sformatf("outputs_bp%0d_k%0d", bp, k[i]), 32'(a), 32'(e));
                // Downstream shift_register chained on serial_out/ena_out.
                if (k[i] == 1) q_model[i] = '0;
                if (ena_out[i]) q_model[i] = {q_model[i][NB-2:0], serial_out[i]};
                if (k[i] == nt + 1) check($sformatf("q_at_done_bp%0d", bp), 32'(q_model[i]), 32'(exp_bits[i]));
            end
        end
    end

    typedef struct {
        logic [N-1:0]  word;
        logic [NB-1:0] stream;
    } vec_t;
    vec_t vecs [6];

    task automatic send(input logic [N-1:0] w);
        @(negedge clk);
        word_in[0] = w;
        word_in[1] = w;
        valid_in   = 2'b11;
        @(negedge clk);
        valid_in   = 2'b00;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(k[0] == 0 && k[1] == 0) && n < 200);
        check("idle_reached", 32'(k[0] == 0 && k[1] == 0), 32'd1);
    endtask

    initial begin
        int cyc;
`ifdef PISO_PARITY_EN
        vecs[0] = '{4'b1010, 5'b10100};
        vecs[1] = '{4'b0110, 5'b01100};
        vecs[2] = '{4'b1011, 5'b10111};
        vecs[3] = '{4'b1001, 5'b10010};
        vecs[4] = '{4'b0001, 5'b00011};
        vecs[5] = '{4'b1111, 5'b11110};
`else
        vecs[0] = '{4'b1010, 4'b1010};
        vecs[1] = '{4'b0110, 4'b0110};
        vecs[2] = '{4'b1011, 4'b1011};
        vecs[3] = '{4'b1001, 4'b1001};
        vecs[4] = '{4'b0001, 4'b0001};
        vecs[5] = '{4'b1111, 4'b1111};
`endif
        valid_in   = 2'b00;
        word_in[0] = '0;
        word_in[1] = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            check("reset_outputs", 32'({ready_out[i], busy[i], ena_out[i], serial_out[i], done[i]}), 32'b10000);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].word);
            wait_idle();
            check($sformatf("vec%0d_q_bp1", v), 32'(q_model[0]), 32'(vecs[v].stream));
            check($sformatf("vec%0d_q_bp3", v), 32'(q_model[1]), 32'(vecs[v].stream));
        end

        // Acceptance-to-done latency on the BIT_PERIOD=3 instance.
        @(negedge clk);
        word_in[1] = 4'b0110;
        valid_in   = 2'b10;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) valid_in = 2'b00;
        end while (!done[1] && cyc < 60);
        check("done_latency_bp3", 32'(cyc), 32'(NB * 3 + 1));
        wait_idle();

        // valid held high while word_in churns every cycle.
        @(negedge clk);
        valid_in = 2'b11;
        for (int c = 0; c < 60; c++) begin
            word_in[0] = 4'($urandom);
            word_in[1] = 4'($urandom);
            @(negedge clk);
        end
        for (int c = 0; c < 300; c++) begin
            valid_in   = 2'($urandom_range(0, 3));
            word_in[0] = 4'($urandom);
            word_in[1] = 4'($urandom);
            @(negedge clk);
        end
        valid_in = 2'b00;
        wait_idle();

        // Abort mid-word after two strobes on the BIT_PERIOD=1 instance.
        send(4'b1111);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            check("abort_outputs", 32'({ready_out[i], busy[i], ena_out[i], serial_out[i], done[i]}), 32'b10000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(vecs[4].word);
        wait_idle();
        check("post_abort_q_bp1", 32'(q_model[0]), 32'(vecs[4].stream));
        check("post_abort_q_bp3", 32'(q_model[1]), 32'(vecs[4].stream));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
